// File: rtl/led_ctrl_pkg.sv
// Shared mode encodings, initial LED patterns and bounce direction for led_pattern_ctrl.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  localparam logic [3:0] LED_INIT_BLINK  = 4'b1111;
  localparam logic [3:0] LED_INIT_CHASE  = 4'b0001;
  localparam logic [3:0] LED_INIT_BOUNCE = 4'b0001;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Pattern loaded on the edge after a mode change; DIRECT starts from the switches.
  function automatic logic [3:0] led_init(input mode_e mode, input logic [3:0] sw_db);
    case (mode)
      MODE_BLINK:  return LED_INIT_BLINK;
      MODE_CHASE:  return LED_INIT_CHASE;
      MODE_BOUNCE: return LED_INIT_BOUNCE;
      default:     return sw_db;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_ctrl_if.sv
// Switch/LED pin bundle: master drives the switches, slave (the controller) drives the LEDs.
interface led_pattern_ctrl_if;
  logic [3:0] sw;
  logic [3:0] led;
  logic       tick;

  modport master (output sw, input led, input tick);
  modport slave  (input sw, output led, output tick);
endinterface

// File: rtl/sw_debounce.sv
// One switch bit: 2-FF synchroniser followed by a stable-count debouncer.
module sw_debounce #(
  parameter int unsigned CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic db_o
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic          sync1_q, sync2_q, db_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      if (sync2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(CYCLES - 1)) begin
        db_q  <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED sequencer: debounced switches select mode (sw[1:0]) and step speed (sw[3:2]).
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TICK_CYCLES     = 12_500_000
) (
  input  logic               clk,
  input  logic               rst_n,
  led_pattern_ctrl_if.slave  bus
);

  localparam int unsigned PW  = $clog2(TICK_CYCLES * 8);
  localparam int unsigned PW1 = PW + 1;

  logic [3:0]    sw_db;
  mode_e         mode_q, mode_d;
  logic [PW-1:0] cnt_q;
  logic [3:0]    led_q;
  logic          tick_q, dir_q, load_q;
  logic [PW:0]   period_c;
  logic [PW-1:0] period_m1_c;
  logic          tick_c, chg_c;

  for (genvar i = 0; i < 4; i++) begin : g_db
    sw_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw_i (bus.sw[i]),
      .db_o  (sw_db[i])
    );
  end

  // Period is one bit wider so 8x the base still fits before subtracting one.
  assign period_c    = PW1'(TICK_CYCLES) << sw_db[3:2];
  assign period_m1_c = PW'(period_c - PW1'(1));
  assign mode_d      = mode_e'(sw_db[1:0]);
  assign chg_c       = (mode_d != mode_q);
  assign tick_c      = (cnt_q >= period_m1_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_DIRECT;
      cnt_q  <= '0;
      led_q  <= 4'b0000;
      tick_q <= 1'b0;
      dir_q  <= DIR_UP;
      load_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      load_q <= 1'b0;
      if (chg_c) begin
        // Mode change wins over a coincident tick; the new pattern loads next edge.
        mode_q <= mode_d;
        cnt_q  <= '0;
        dir_q  <= DIR_UP;
        load_q <= 1'b1;
        if (mode_q == MODE_DIRECT) led_q <= sw_db;
      end else begin
        if (tick_c) begin
          cnt_q  <= '0;
          tick_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + PW'(1);
        end
        if (load_q) begin
          led_q <= led_init(mode_q, sw_db);
        end else begin
          case (mode_q)
            MODE_DIRECT: led_q <= sw_db;
            MODE_BLINK:  if (tick_c) led_q <= ~led_q;
            MODE_CHASE:  if (tick_c) led_q <= {led_q[2:0], led_q[3]};
            MODE_BOUNCE: begin
              if (tick_c) begin
                if (dir_q == DIR_UP) begin
                  led_q <= {led_q[2:0], 1'b0};
                  if (led_q[2]) dir_q <= DIR_DOWN;
                end else begin
                  led_q <= {1'b0, led_q[3:1]};
                  if (led_q[1]) dir_q <= DIR_UP;
                end
              end
            end
          endcase
        end
      end
    end
  end

  assign bus.led  = led_q;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with DEBOUNCE_CYCLES=4, TICK_CYCLES=8.
module tb_led_pattern_ctrl;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   n;

  led_pattern_ctrl_if bus_if ();

  led_pattern_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Steps until a tick is seen or the budget runs out; returns cycles taken.
  task automatic wait_tick(input int max_cycles, output int cycles);
    cycles = 0;
    do begin
      step(1);
      cycles++;
    end while (bus_if.tick !== 1'b1 && cycles < max_cycles);
  endtask

  logic [3:0] chase_exp  [4];
  logic [3:0] bounce_exp [10];

  initial begin
    tests = 0;
    fails = 0;
    chase_exp  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bounce_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010,
                   4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};

    // Reset held with all switches on
    rst_n     = 1'b0;
    bus_if.sw = 4'b1111;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk4("rst_led", bus_if.led, 4'b0000);
      chk1("rst_tick", bus_if.tick, 1'b0);
      step(1);
    end
    rst_n = 1'b1;
    step(6);
    chk4("rst_lat_early", bus_if.led, 4'b0000);
    step(1);
    chk4("rst_lat_exact", bus_if.led, 4'b1111);
    step(1);
    chk4("rst_bounce_init", bus_if.led, 4'b0001);

    // Back to DIRECT with all switches off
    bus_if.sw = 4'b0000;
    step(8);
    chk4("direct_zero", bus_if.led, 4'b0000);

    // 3-cycle glitch must be rejected
    bus_if.sw = 4'b0001;
    step(3);
    bus_if.sw = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk1("glitch_led0", bus_if.led[0], 1'b0);
    end

    // Stable high: led[0] follows after 2+4+1 cycles, then BLINK init
    bus_if.sw = 4'b0001;
    step(6);
    chk4("db_early", bus_if.led, 4'b0000);
    step(1);
    chk4("db_exact", bus_if.led, 4'b0001);
    step(1);
    chk4("blink_init", bus_if.led, 4'b1111);

    // CHASE at base speed
    bus_if.sw = 4'b0010;
    step(8);
    chk4("chase_init", bus_if.led, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      step((i == 0) ? 6 : 7);
      chk1("chase_no_tick", bus_if.tick, 1'b0);
      step(1);
      chk1("chase_tick", bus_if.tick, 1'b1);
      chk4("chase_led", bus_if.led, chase_exp[i]);
    end

    // CHASE at 8x: speed-only change keeps the pattern running
    bus_if.sw = 4'b1110;
    step(7);
    wait_tick(200, n);
    chk1("chase_s3_first", bus_if.tick, 1'b1);
    wait_tick(200, n);
    chkn("chase_s3_period", n, 64);

    // BLINK entered mid-CHASE at base speed
    bus_if.sw = 4'b0001;
    step(8);
    chk4("blink_enter", bus_if.led, 4'b1111);
    step(6);
    chk4("blink_hold", bus_if.led, 4'b1111);
    step(1);
    chk4("blink_off", bus_if.led, 4'b0000);
    chk1("blink_tick", bus_if.tick, 1'b1);
    step(8);
    chk4("blink_on", bus_if.led, 4'b1111);

    // Slow to 8x, then drop back to 1x when the count is at 40
    bus_if.sw = 4'b1101;
    step(7);
    wait_tick(200, n);
    chk1("blink_s3_tick", bus_if.tick, 1'b1);
    step(34);
    bus_if.sw = 4'b0001;
    step(6);
    chk1("speed_drop_none", bus_if.tick, 1'b0);
    step(1);
    chk1("speed_drop_tick", bus_if.tick, 1'b1);
    chk1("speed_drop_legal", (bus_if.led == 4'b0000) || (bus_if.led == 4'b1111), 1'b1);
    step(7);
    chk1("speed_base_none", bus_if.tick, 1'b0);
    step(1);
    chk1("speed_base_tick", bus_if.tick, 1'b1);

    // BOUNCE at base speed, ten steps ending on the way down
    bus_if.sw = 4'b0011;
    step(8);
    chk4("bounce_init", bus_if.led, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      step((i == 0) ? 6 : 7);
      chk1("bounce_no_tick", bus_if.tick, 1'b0);
      step(1);
      chk1("bounce_tick", bus_if.tick, 1'b1);
      chk4("bounce_led", bus_if.led, bounce_exp[i]);
    end

    // Asynchronous reset while moving down
    #2;
    rst_n = 1'b0;
    #1;
    chk4("async_rst_led", bus_if.led, 4'b0000);
    chk1("async_rst_tick", bus_if.tick, 1'b0);
    step(2);
    chk4("async_rst_hold", bus_if.led, 4'b0000);
    rst_n = 1'b1;
    step(7);
    chk4("rerun_direct", bus_if.led, 4'b0011);
    step(1);
    chk4("rerun_init", bus_if.led, 4'b0001);
    step(7);
    chk4("rerun_up1", bus_if.led, 4'b0010);
    chk1("rerun_tick", bus_if.tick, 1'b1);
    step(8);
    chk4("rerun_up2", bus_if.led, 4'b0100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
